scproc_mem_sequencer: RTL and testbench



---
 rtl/scproc_mem_sequencer.sv | 147 ++++++++++++++
 tb/tb_scproc_mem_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scproc_mem_sequencer.sv
// Data-memory sequencer for the single-cycle core: arbitrates core and debug
// requesters onto one fixed-latency single-port memory and produces the core commit strobe.
module scproc_mem_sequencer #(
    parameter int DBITS   = 32,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coreReq,
    input  logic             coreWe,
    input  logic [DBITS-1:0] coreAddr,
    input  logic [DBITS-1:0] coreWdata,
    output logic [DBITS-1:0] coreRdata,
    output logic             lock,
    input  logic             dbgReq,
    input  logic             dbgWe,
    input  logic [DBITS-1:0] dbgAddr,
    input  logic [DBITS-1:0] dbgWdata,
    output logic [DBITS-1:0] dbgRdata,
    output logic             dbgAck,
    output logic             memEn,
    output logic             memWe,
    output logic [DBITS-1:0] memAddr,
    output logic [DBITS-1:0] memWdata,
    input  logic [DBITS-1:0] memRdata
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e           state_q;
    logic             grant_q;
    logic             last_grant_q;
    logic             mem_en_q;
    logic             mem_we_q;
    logic             dbg_ack_q;
    logic [3:0]       cnt_q;
    logic [DBITS-1:0] mem_addr_q;
    logic [DBITS-1:0] mem_wdata_q;
    logic [DBITS-1:0] rdata_q;

    logic             any_req_d;
    logic             win_dbg_d;
    logic             win_we_d;
    logic [DBITS-1:0] win_addr_d;
    logic [DBITS-1:0] win_wdata_d;

    // Round-robin pick: on contention the side that did not win last time goes next.
    always_comb begin
        any_req_d = coreReq | dbgReq;
        if (coreReq && dbgReq) begin
            win_dbg_d = ~last_grant_q;
        end else if (dbgReq) begin
            win_dbg_d = 1'b1;
        end else begin
            win_dbg_d = 1'b0;
        end
        if (win_dbg_d) begin
            win_we_d    = dbgWe;
            win_addr_d  = dbgAddr;
            win_wdata_d = dbgWdata;
        end else begin
            win_we_d    = coreWe;
            win_addr_d  = coreAddr;
            win_wdata_d = coreWdata;
        end
    end

    // Access sequencer: grant in IDLE, wait out the memory latency, pulse completion in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cnt_q        <= 4'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dbg_ack_q <= 1'b0;
                    if (any_req_d) begin
                        grant_q      <= win_dbg_d;
                        last_grant_q <= win_dbg_d;
                        mem_en_q     <= 1'b1;
                        mem_we_q     <= win_we_d;
                        mem_addr_q   <= win_addr_d;
                        mem_wdata_q  <= win_wdata_d;
                        cnt_q        <= LAT_LOAD;
                        state_q      <= ST_ACCESS;
                    end else begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Command is a single-cycle strobe; address and data hold afterwards.
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    cnt_q    <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        rdata_q   <= memRdata;
                        dbg_ack_q <= grant_q;
                        state_q   <= ST_DONE;
                    end else begin
                        dbg_ack_q <= 1'b0;
                        state_q   <= ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    mem_en_q  <= 1'b0;
                    mem_we_q  <= 1'b0;
                    dbg_ack_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    mem_en_q  <= 1'b0;
                    mem_we_q  <= 1'b0;
                    dbg_ack_q <= 1'b0;
                    cnt_q     <= 4'd0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // A core instruction without a memory access commits unconditionally.
    assign lock      = ~coreReq | ((state_q == ST_DONE) & ~grant_q);
    assign dbgAck    = dbg_ack_q;
    assign coreRdata = rdata_q;
    assign dbgRdata  = rdata_q;
    assign memEn     = mem_en_q;
    assign memWe     = mem_we_q;
    assign memAddr   = mem_addr_q;
    assign memWdata  = mem_wdata_q;

endmodule

// File: tb/tb_scproc_mem_sequencer.sv
// Scoreboard bench for scproc_mem_sequencer: directed accesses push expected
// commands/completions; a negedge monitor pops and compares.
module tb_scproc_mem_sequencer;
    localparam int LAT = 2;

    typedef struct {int at; logic [31:0] data; bit chkd;} cpl_t;
    typedef struct {int at; logic we; logic [31:0] addr; logic [31:0] wdata;} cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic coreReq, coreWe, lock, dbgReq, dbgWe, dbgAck, memEn, memWe;
    logic [31:0] coreAddr, coreWdata, coreRdata, dbgAddr, dbgWdata, dbgRdata;
    logic [31:0] memAddr, memWdata, memRdata;

    logic cr1, lock1, dbgAck1, memEn1, memWe1;
    logic [31:0] coreRdata1, dbgRdata1, memAddr1, memWdata1, memRdata1;
    logic cr15, lock15, dbgAck15, memEn15, memWe15;
    logic [31:0] coreRdata15, dbgRdata15, memAddr15, memWdata15, memRdata15;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    cpl_t exp_core_q[$], exp_dbg_q[$], exp_l1_q[$], exp_l15_q[$];
    cmd_t exp_cmd_q[$];

    logic [31:0] mem [0:255];
    int          last_en = -1000;
    logic [7:0]  last_addr = 8'd0;
    int          en15 = -1000;

    scproc_mem_sequencer #(.DBITS(32), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .coreReq(coreReq), .coreWe(coreWe), .coreAddr(coreAddr), .coreWdata(coreWdata),
        .coreRdata(coreRdata), .lock(lock),
        .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWdata(dbgWdata),
        .dbgRdata(dbgRdata), .dbgAck(dbgAck),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata)
    );

    scproc_mem_sequencer #(.DBITS(32), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .coreReq(cr1), .coreWe(1'b0), .coreAddr(32'h0000_0020), .coreWdata(32'h0),
        .coreRdata(coreRdata1), .lock(lock1),
        .dbgReq(1'b0), .dbgWe(1'b0), .dbgAddr(32'h0), .dbgWdata(32'h0),
        .dbgRdata(dbgRdata1), .dbgAck(dbgAck1),
        .memEn(memEn1), .memWe(memWe1), .memAddr(memAddr1), .memWdata(memWdata1),
        .memRdata(memRdata1)
    );

    scproc_mem_sequencer #(.DBITS(32), .MEM_LAT(15)) u_lat15 (
        .clk(clk), .reset(reset),
        .coreReq(cr15), .coreWe(1'b0), .coreAddr(32'h0000_0030), .coreWdata(32'h0),
        .coreRdata(coreRdata15), .lock(lock15),
        .dbgReq(1'b0), .dbgWe(1'b0), .dbgAddr(32'h0), .dbgWdata(32'h0),
        .dbgRdata(dbgRdata15), .dbgAck(dbgAck15),
        .memEn(memEn15), .memWe(memWe15), .memAddr(memAddr15), .memWdata(memWdata15),
        .memRdata(memRdata15)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: read data is valid only in the single cycle the sequencer samples it.
    always @(posedge clk) begin
        if (cyc == 0) begin
            mem[16] <= 32'hDEAD_BEEF;
            mem[17] <= 32'h55AA_55AA;
            mem[32] <= 32'hCAFE_F00D;
        end
        if (memEn) begin
            last_en   <= cyc;
            last_addr <= memAddr[9:2];
            if (memWe) mem[memAddr[9:2]] <= memWdata;
        end
        if (memEn15) en15 <= cyc;
    end
    assign memRdata   = (cyc == last_en + LAT - 1) ? mem[last_addr] : 32'hBAD0_BAD0;
    assign memRdata1  = memEn1 ? (memAddr1 ^ 32'h1111_0000) : 32'hBAD1_BAD1;
    assign memRdata15 = (cyc == en15 + 14) ? (memAddr15 ^ 32'hF0F0_0000) : 32'hBADF_BADF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %08h, required %08h", name, cyc, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d: got an event, required none", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a command or completion.
    initial begin
        cpl_t c;
        cmd_t m;
        logic [31:0] prev_addr = 32'h0;
        logic [31:0] prev_wdata = 32'h0;
        bit rst_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (coreReq && lock) begin
                if (exp_core_q.size() == 0) flag("core_lock_unexpected");
                else begin
                    c = exp_core_q.pop_front();
                    chk("core_lock_cycle", cyc, c.at);
                    if (c.chkd) chk("core_rdata", coreRdata, c.data);
                end
            end
            if (!coreReq) chk("lock_no_mem_instr", {31'd0, lock}, 32'd1);
            if (dbgAck) begin
                if (exp_dbg_q.size() == 0) flag("dbg_ack_unexpected");
                else begin
                    c = exp_dbg_q.pop_front();
                    chk("dbg_ack_cycle", cyc, c.at);
                    if (c.chkd) chk("dbg_rdata", dbgRdata, c.data);
                end
            end
            if (memEn) begin
                if (exp_cmd_q.size() == 0) flag("mem_en_unexpected");
                else begin
                    m = exp_cmd_q.pop_front();
                    chk("mem_en_cycle", cyc, m.at);
                    chk("mem_we", {31'd0, memWe}, {31'd0, m.we});
                    chk("mem_addr", memAddr, m.addr);
                    chk("mem_wdata", memWdata, m.wdata);
                end
            end else begin
                chk("mem_we_without_en", {31'd0, memWe}, 32'd0);
                if (!reset && !rst_prev) begin
                    chk("mem_addr_hold", memAddr, prev_addr);
                    chk("mem_wdata_hold", memWdata, prev_wdata);
                end
            end
            if (cr1 && lock1) begin
                if (exp_l1_q.size() == 0) flag("lat1_lock_unexpected");
                else begin
                    c = exp_l1_q.pop_front();
                    chk("lat1_lock_cycle", cyc, c.at);
                    chk("lat1_rdata", coreRdata1, c.data);
                end
            end
            if (cr15 && lock15) begin
                if (exp_l15_q.size() == 0) flag("lat15_lock_unexpected");
                else begin
                    c = exp_l15_q.pop_front();
                    chk("lat15_lock_cycle", cyc, c.at);
                    chk("lat15_rdata", coreRdata15, c.data);
                end
            end
            prev_addr  = memAddr;
            prev_wdata = memWdata;
            rst_prev   = reset;
        end
    end

    task automatic core_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] edata, input bit chkd);
        int n = cyc;
        coreReq = 1'b1; coreWe = we; coreAddr = addr; coreWdata = wdata;
        exp_cmd_q.push_back('{n + 1, we, addr, wdata});
        exp_core_q.push_back('{n + LAT + 1, edata, chkd});
        repeat (LAT + 2) tick();
        coreReq = 1'b0;
    endtask

    task automatic dbg_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] edata, input bit chkd, input bit hold);
        int n = cyc;
        dbgReq = 1'b1; dbgWe = we; dbgAddr = addr; dbgWdata = wdata;
        exp_cmd_q.push_back('{n + 1, we, addr, wdata});
        exp_dbg_q.push_back('{n + LAT + 1, edata, chkd});
        tick();
        if (!hold) dbgReq = 1'b0;
        repeat (LAT + 1) tick();
        dbgReq = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        coreReq = 1'b0; coreWe = 1'b0; coreAddr = 32'h0; coreWdata = 32'h0;
        dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = 32'h0; dbgWdata = 32'h0;
        cr1 = 1'b0; cr15 = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_mem_en", {31'd0, memEn}, 32'd0);
        chk("rst_mem_addr", memAddr, 32'h0);
        chk("rst_mem_wdata", memWdata, 32'h0);
        chk("rst_dbg_ack", {31'd0, dbgAck}, 32'd0);
        chk("rst_core_rdata", coreRdata, 32'h0);
        chk("rst_lock", {31'd0, lock}, 32'd1);
        tick();
        reset = 1'b0;

        core_op(1'b0, 32'h0000_0040, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1);
        core_op(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0);
        core_op(1'b0, 32'h0000_0010, 32'h0000_0002, 32'h1234_5678, 1'b1);
        dbg_op(1'b0, 32'h0000_0080, 32'h0000_0003, 32'hCAFE_F00D, 1'b1, 1'b1);
        dbg_op(1'b1, 32'h0000_0084, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1);
        dbg_op(1'b0, 32'h0000_0084, 32'h0000_0004, 32'h0BAD_F00D, 1'b1, 1'b0);

        // Contention held from reset release: core, debug, core.
        reset = 1'b1;
        coreReq = 1'b1; coreWe = 1'b0; coreAddr = 32'h0000_0040; coreWdata = 32'h0000_0005;
        dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 32'h0000_0080; dbgWdata = 32'h0000_0006;
        tick();
        @(negedge clk);
        chk("lock_in_reset_core_req", {31'd0, lock}, 32'd0);
        tick();
        reset = 1'b0;
        n = cyc;
        exp_cmd_q.push_back('{n + 1, 1'b0, 32'h0000_0040, 32'h0000_0005});
        exp_core_q.push_back('{n + 3, 32'hDEAD_BEEF, 1'b1});
        exp_cmd_q.push_back('{n + 5, 1'b0, 32'h0000_0080, 32'h0000_0006});
        exp_dbg_q.push_back('{n + 7, 32'hCAFE_F00D, 1'b1});
        exp_cmd_q.push_back('{n + 9, 1'b0, 32'h0000_0040, 32'h0000_0005});
        exp_core_q.push_back('{n + 11, 32'hDEAD_BEEF, 1'b1});
        repeat (12) tick();
        coreReq = 1'b0; dbgReq = 1'b0;

        // Reset one cycle after memEn, then a fresh request with normal latency.
        n = cyc;
        coreReq = 1'b1; coreAddr = 32'h0000_0040; coreWdata = 32'h0000_0007;
        exp_cmd_q.push_back('{n + 1, 1'b0, 32'h0000_0040, 32'h0000_0007});
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        coreAddr = 32'h0000_0044;
        exp_cmd_q.push_back('{n + 4, 1'b0, 32'h0000_0044, 32'h0000_0007});
        exp_core_q.push_back('{n + 6, 32'h55AA_55AA, 1'b1});
        repeat (4) tick();
        coreReq = 1'b0;

        n = cyc;
        cr1 = 1'b1;
        exp_l1_q.push_back('{n + 2, 32'h1111_0020, 1'b1});
        repeat (3) tick();
        cr1 = 1'b0;
        n = cyc;
        cr15 = 1'b1;
        exp_l15_q.push_back('{n + 16, 32'hF0F0_0030, 1'b1});
        repeat (17) tick();
        cr15 = 1'b0;

        repeat (3) tick();
        chk("core_q_drained", exp_core_q.size(), 32'd0);
        chk("dbg_q_drained", exp_dbg_q.size(), 32'd0);
        chk("cmd_q_drained", exp_cmd_q.size(), 32'd0);
        chk("lat1_q_drained", exp_l1_q.size(), 32'd0);
        chk("lat15_q_drained", exp_l15_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
